// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: request/operand/status bundle between the pipeline
// controller (master) and the multi-cycle ALU (slave).
interface multicycle_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;

  modport master (
    output start, op_code, operand1, operand2,
    input  busy, done, result, zero, neg, carry, ovf
  );

  modport slave (
    input  start, op_code, operand1, operand2,
    output busy, done, result, zero, neg, carry, ovf
  );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu: registered ALU with a start/done handshake. Most ops finish
// at the start edge. MUL is an iterative shift-add that takes WIDTH cycles and
// works on latched operand copies. Status flags are registered with the result.
module multicycle_alu #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_alu_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam logic [2:0]       OP_ADD  = 3'b000;
  localparam logic [2:0]       OP_SUB  = 3'b001;
  localparam logic [2:0]       OP_AND  = 3'b010;
  localparam logic [2:0]       OP_NOT  = 3'b011;
  localparam logic [2:0]       OP_OR   = 3'b100;
  localparam logic [2:0]       OP_SHL  = 3'b101;
  localparam logic [2:0]       OP_MUL  = 3'b110;
  localparam logic [2:0]       OP_PASS = 3'b111;
  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam int               MSB      = WIDTH - 1;

  state_t           state_r;
  state_t           state_nx_s;
  logic [WIDTH-1:0] op1_r;
  logic [WIDTH-1:0] op2_r;
  logic [WIDTH-1:0] acc_r;
  logic [SHW-1:0]   cnt_r;
  logic [WIDTH-1:0] result_r;
  logic             busy_r;
  logic             done_r;
  logic             zero_r;
  logic             neg_r;
  logic             carry_r;
  logic             ovf_r;

  logic             accept_s;
  logic             mul_last_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_carry_s;
  logic             alu_ovf_s;
  logic [WIDTH:0]   wide_s;
  logic [SHW-1:0]   sh_amt_s;
  logic [WIDTH-1:0] acc_nx_s;

  // A request is only taken while idle; starts during a multiply are dropped.
  assign accept_s   = (state_r == ST_IDLE) && bus.start;
  assign mul_last_s = (state_r == ST_MUL) && (cnt_r == CNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: only MUL leaves IDLE, and it returns after WIDTH steps.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (bus.op_code == OP_MUL)) begin
          state_nx_s = ST_MUL;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_MUL;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Single-cycle datapath: result, carry/borrow/shift-out and signed overflow.
  always_comb begin
    alu_res_s   = ZERO_W;
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    wide_s      = {(WIDTH+1){1'b0}};
    sh_amt_s    = bus.operand2[SHW-1:0];
    case (bus.op_code)
      OP_ADD: begin
        wide_s      = {1'b0, bus.operand1} + {1'b0, bus.operand2};
        alu_res_s   = wide_s[WIDTH-1:0];
        alu_carry_s = wide_s[WIDTH];
        alu_ovf_s   = (bus.operand1[MSB] == bus.operand2[MSB]) &&
                      (alu_res_s[MSB] != bus.operand1[MSB]);
      end
      OP_SUB: begin
        // The extra top bit of the difference is the unsigned borrow.
        wide_s      = {1'b0, bus.operand1} - {1'b0, bus.operand2};
        alu_res_s   = wide_s[WIDTH-1:0];
        alu_carry_s = wide_s[WIDTH];
        alu_ovf_s   = (bus.operand1[MSB] != bus.operand2[MSB]) &&
                      (alu_res_s[MSB] != bus.operand1[MSB]);
      end
      OP_AND:  alu_res_s = bus.operand1 & bus.operand2;
      OP_NOT:  alu_res_s = ~bus.operand2;
      OP_OR:   alu_res_s = bus.operand1 | bus.operand2;
      OP_SHL: begin
        // Shifting into a one-bit-wider word leaves the last bit out on top.
        wide_s      = {1'b0, bus.operand1} << sh_amt_s;
        alu_res_s   = wide_s[WIDTH-1:0];
        alu_carry_s = wide_s[WIDTH];
      end
      OP_MUL:  alu_res_s = ZERO_W;
      OP_PASS: alu_res_s = bus.operand1;
      default: alu_res_s = ZERO_W;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_nx_s = acc_r;
    if (op2_r[cnt_r]) begin
      acc_nx_s = acc_r + (op1_r << cnt_r);
    end else begin
      acc_nx_s = acc_r;
    end
  end

  // Operand latches, multiply accumulator, and registered result/flags/handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_r    <= ZERO_W;
      op2_r    <= ZERO_W;
      acc_r    <= ZERO_W;
      cnt_r    <= {SHW{1'b0}};
      result_r <= ZERO_W;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      zero_r   <= 1'b0;
      neg_r    <= 1'b0;
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_nx_s == ST_MUL);
      if (accept_s) begin
        if (bus.op_code == OP_MUL) begin
          op1_r <= bus.operand1;
          op2_r <= bus.operand2;
          acc_r <= ZERO_W;
          cnt_r <= {SHW{1'b0}};
        end else begin
          result_r <= alu_res_s;
          zero_r   <= (alu_res_s == ZERO_W);
          neg_r    <= alu_res_s[MSB];
          carry_r  <= alu_carry_s;
          ovf_r    <= alu_ovf_s;
          done_r   <= 1'b1;
        end
      end else if (state_r == ST_MUL) begin
        acc_r <= acc_nx_s;
        cnt_r <= cnt_r + CNT_ONE;
        if (mul_last_s) begin
          result_r <= acc_nx_s;
          zero_r   <= (acc_nx_s == ZERO_W);
          neg_r    <= acc_nx_s[MSB];
          carry_r  <= 1'b0;
          ovf_r    <= 1'b0;
          done_r   <= 1'b1;
        end
      end
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.zero   = zero_r;
  assign bus.neg    = neg_r;
  assign bus.carry  = carry_r;
  assign bus.ovf    = ovf_r;

endmodule
